// File: rtl/timer_sched_pkg.sv
// Shared definitions for the timer scheduler: state encoding and the
// default geometry used when the top is instantiated without overrides.
package timer_sched_pkg;

   localparam int DEFAULT_N_REQ = 4;
   localparam int DEFAULT_CNT_W = 16;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_COUNT = 3'd2,
      ST_PAUSE = 3'd3,
      ST_DONE  = 3'd4
   } state_e;

endpackage

// File: rtl/timer_sched_rr_arbiter.sv
// Combinational arbiter picking which requester gets the shared timer next.
// Default build: round-robin, searching upward from last+1 with wrap.
// With TIMER_SCHED_FIXED_PRIO_EN defined: the lowest requesting index wins
// and the last input is ignored.
module rr_arbiter
   import timer_sched_pkg::*;
#(
   parameter int N_REQ = DEFAULT_N_REQ,
   parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] last,
   output logic [N_REQ-1:0] grant,
   output logic [IDX_W-1:0] grant_idx
);

`ifdef TIMER_SCHED_FIXED_PRIO_EN

   logic unused_last;
   assign unused_last = ^last;

   // Scan from the top down so the lowest requesting index is the final writer
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (req[i]) begin
            grant     = '0;
            grant[i]  = 1'b1;
            grant_idx = IDX_W'(i);
         end
      end
   end

`else

   logic             found;
   logic [IDX_W-1:0] pos;

   // Walk the requesters starting just after the previous owner, first hit wins
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      pos       = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         pos = IDX_W'((int'(last) + k) % N_REQ);
         if (!found && req[pos]) begin
            found      = 1'b1;
            grant[pos] = 1'b1;
            grant_idx  = pos;
         end
      end
   end

`endif

endmodule

// File: rtl/timer_sched.sv
// Shares one countdown timer between N_REQ requesters: arbitrate, load the
// winner's timeout, count down (freezing while pause is high), then pulse
// done back to the winner for one cycle.
// Optional macro TIMER_SCHED_FIXED_PRIO_EN switches the arbiter from
// round-robin to fixed lowest-index priority.
module timer_sched
   import timer_sched_pkg::*;
#(
   parameter int N_REQ = DEFAULT_N_REQ,
   parameter int CNT_W = DEFAULT_CNT_W
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [N_REQ-1:0]       req,
   input  logic [N_REQ*CNT_W-1:0] load_val,
   input  logic                   pause,
   output logic [N_REQ-1:0]       grant,
   output logic                   busy,
   output logic [CNT_W-1:0]       count,
   output logic [N_REQ-1:0]       done
);

   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   state_e           state_q,  state_d;
   logic [IDX_W-1:0] winner_q, winner_d;
   logic [IDX_W-1:0] last_q,   last_d;
   logic [N_REQ-1:0] grant_q,  grant_d;
   logic [CNT_W-1:0] count_q,  count_d;

   logic [N_REQ-1:0] arb_grant;
   logic [IDX_W-1:0] arb_idx;
   logic [CNT_W-1:0] cur_load;
   logic             owner_req;

   rr_arbiter #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_arb (
      .req       (req),
      .last      (last_q),
      .grant     (arb_grant),
      .grant_idx (arb_idx)
   );

   // Select the registered winner's timeout length from the packed bus
   always_comb begin
      cur_load = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (winner_q == IDX_W'(i)) begin
            cur_load = load_val[i*CNT_W +: CNT_W];
         end
      end
   end

   assign owner_req = req[winner_q];

   // Next-state logic; abandon outranks pause, which outranks expiry
   always_comb begin
      state_d  = state_q;
      winner_d = winner_q;
      last_d   = last_q;
      grant_d  = grant_q;
      count_d  = count_q;
      case (state_q)
         ST_IDLE: begin
            grant_d = '0;
            if (|req) begin
               winner_d = arb_idx;
               grant_d  = arb_grant;
               state_d  = ST_LOAD;
            end
         end
         ST_LOAD: begin
            count_d = cur_load;
            state_d = (cur_load == '0) ? ST_DONE : ST_COUNT;
         end
         ST_COUNT: begin
            if (!owner_req) begin
               state_d = ST_IDLE;
               count_d = '0;
               grant_d = '0;
               last_d  = winner_q;
            end else if (pause) begin
               state_d = ST_PAUSE;
            end else if (count_q == CNT_W'(1)) begin
               state_d = ST_DONE;
               count_d = '0;
            end else begin
               count_d = count_q - CNT_W'(1);
            end
         end
         ST_PAUSE: begin
            if (!owner_req) begin
               state_d = ST_IDLE;
               count_d = '0;
               grant_d = '0;
               last_d  = winner_q;
            end else if (!pause) begin
               state_d = ST_COUNT;
            end
         end
         ST_DONE: begin
            last_d  = winner_q;
            grant_d = '0;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            grant_d = '0;
            count_d = '0;
         end
      endcase
   end

   // State and datapath registers; reset also restores the round-robin pointer
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         winner_q <= '0;
         last_q   <= IDX_W'(N_REQ - 1);
         grant_q  <= '0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         winner_q <= winner_d;
         last_q   <= last_d;
         grant_q  <= grant_d;
         count_q  <= count_d;
      end
   end

   assign grant = grant_q;
   assign count = count_q;
   assign busy  = (state_q != ST_IDLE);
   assign done  = (state_q == ST_DONE) ? grant_q : '0;

endmodule
